// File: rtl/multdiv_issue_ctrl_if.sv
// Signal bundle between the pipeline/multdiv side and the multdiv issue controller.
// The controller uses the slave view; the pipeline and multdiv side use the master view.
interface multdiv_issue_ctrl_if #(
  parameter int REG_W = 5
);
  // Request from the pipeline
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [REG_W-1:0] req_rd;
  logic             flush;

  // Multdiv unit
  logic             md_ctrl_MULT;
  logic             md_ctrl_DIV;
  logic [31:0]      md_operandA;
  logic [31:0]      md_operandB;
  logic [31:0]      md_result;
  logic             md_exception;
  logic             md_resultRDY;

  // Writeback
  logic             wb_valid;
  logic             wb_ready;
  logic [REG_W-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             wb_exception;

  // Decode hazard tracking
  logic             busy;
  logic [REG_W-1:0] busy_rd;
  logic [REG_W-1:0] hz_rs1;
  logic [REG_W-1:0] hz_rs2;
  logic             hz_stall;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, flush,
           md_result, md_exception, md_resultRDY, wb_ready, hz_rs1, hz_rs2,
    output req_ready, md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
           wb_valid, wb_rd, wb_data, wb_exception, busy, busy_rd, hz_stall
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, flush,
           md_result, md_exception, md_resultRDY, wb_ready, hz_rs1, hz_rs2,
    input  req_ready, md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
           wb_valid, wb_rd, wb_data, wb_exception, busy, busy_rd, hz_stall
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issues one MULT/DIV to the multi-cycle multdiv unit, waits for its result under a
// watchdog, and hands the result to writeback while exposing the in-flight rd for stalls.
module multdiv_issue_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 40
) (
  input logic                 clock,
  input logic                 reset_n,
  multdiv_issue_ctrl_if.slave bus
);
  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t           state, state_next;
  logic             op_q;
  logic [31:0]      a_q, b_q, data_q;
  logic [REG_W-1:0] rd_q;
  logic             exc_q;
  logic [TW-1:0]    timer_q;

  logic in_wait, rdy_hit, tmo_hit, capture;

  // Timer is 0 on the first WAIT cycle, where RDY may still be left over from the previous op.
  assign in_wait = (state == S_WAIT) && !bus.flush;
  assign rdy_hit = in_wait && bus.md_resultRDY && (timer_q != '0);
  assign tmo_hit = in_wait && !rdy_hit && (timer_q == TIMER_LAST);
  assign capture = rdy_hit || tmo_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:   if (bus.req_valid) state_next = S_LAUNCH;
      S_LAUNCH: state_next = bus.flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (bus.flush)    state_next = S_IDLE;
        else if (capture) state_next = (rd_q == '0) ? S_IDLE : S_DONE;
      end
      S_DONE:   if (bus.wb_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: datapath registers are reset too, so operand and writeback outputs read 0, not X.
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: if (bus.req_valid) begin
          op_q <= bus.req_op;
          a_q  <= bus.req_a;
          b_q  <= bus.req_b;
          rd_q <= bus.req_rd;
        end
        S_LAUNCH: timer_q <= '0;
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (rdy_hit) begin
            data_q <= bus.md_result;
            exc_q  <= bus.md_exception;
          end else if (tmo_hit) begin
            data_q <= '0;
            exc_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready    = (state == S_IDLE);
    bus.md_ctrl_MULT = (state == S_LAUNCH) && !op_q;
    bus.md_ctrl_DIV  = (state == S_LAUNCH) &&  op_q;
    bus.wb_valid     = (state == S_DONE);
    bus.busy         = (state != S_IDLE);
    bus.busy_rd      = (state != S_IDLE) ? rd_q : '0;
    bus.hz_stall     = (state != S_IDLE) && (rd_q != '0) &&
                       ((bus.hz_rs1 == rd_q) || (bus.hz_rs2 == rd_q));
  end

  assign bus.md_operandA  = a_q;
  assign bus.md_operandB  = b_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = data_q;
  assign bus.wb_exception = exc_q;
endmodule
